// File: rtl/irq_priority_control.sv
// External interrupt controller: per-source pending latches, 64-entry ICT
// filtering, priority-floor arbitration and a hold-until-ack dispatch FSM.
module irq_priority_control #(
  parameter int unsigned      P_SRC       = 8,
  parameter int unsigned      P_EXT_BASE  = 4,
  parameter logic [P_SRC-1:0] P_EDGE_MASK = {P_SRC{1'b0}}
) (
  input  logic             iCLOCK,
  input  logic             iRESET_SYNC,
  input  logic             iICT_VALID,
  input  logic [5:0]       iICT_ENTRY,
  input  logic             iICT_CONF_MASK,
  input  logic             iICT_CONF_VALID,
  input  logic [1:0]       iICT_CONF_LEVEL,
  input  logic [1:0]       iPRIORITY_FLOOR,
  input  logic [P_SRC-1:0] iEXT_IRQ,
  output logic [P_SRC-1:0] oEXT_ACK,
  output logic [P_SRC-1:0] oPENDING,
  input  logic             iEXCEPTION_LOCK,
  output logic             oEXCEPTION_ACTIVE,
  output logic [6:0]       oEXCEPTION_IRQ_NUM,
  input  logic             iEXCEPTION_IRQ_ACK
);

  localparam int unsigned SW = (P_SRC > 1) ? $clog2(P_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic [6:0]             num_q, num_d;
  logic [P_SRC-1:0]       pending_q, pending_d;
  logic [P_SRC-1:0]       prev_q, prev_d;
  logic [P_SRC-1:0]       ext_ack_q, ext_ack_d;
  logic                   ict_mask_q  [64];
  logic                   ict_mask_d  [64];
  logic                   ict_valid_q [64];
  logic                   ict_valid_d [64];
  logic [1:0]             ict_level_q [64];
  logic [1:0]             ict_level_d [64];

  logic [P_SRC-1:0]       enabled_s;
  logic [P_SRC-1:0]       cand_s;
  logic [P_SRC-1:0]       trig_s;
  logic [P_SRC-1:0][1:0]  eff_level_s;
  logic                   win_found_s;
  logic [SW-1:0]          win_idx_s;
  logic [1:0]             win_level_s;
  logic                   ack_fire_s;

  // Per-source view of its ICT entry (entry index is fixed per source).
  for (genvar g = 0; g < P_SRC; g++) begin : g_src
    localparam int unsigned E = P_EXT_BASE + g;
    assign enabled_s[g]   = !ict_valid_q[E] || ict_mask_q[E];
    assign eff_level_s[g] = ict_valid_q[E] ? ict_level_q[E] : 2'd0;
    assign cand_s[g]      = pending_q[g] && enabled_s[g] &&
                            (eff_level_s[g] >= iPRIORITY_FLOOR);
  end

  // ICT next-state: one entry rewritten per strobe.
  always_comb begin
    for (int unsigned e = 0; e < 64; e++) begin
      ict_mask_d[e]  = (iICT_VALID && (iICT_ENTRY == 6'(e))) ? iICT_CONF_MASK  : ict_mask_q[e];
      ict_valid_d[e] = (iICT_VALID && (iICT_ENTRY == 6'(e))) ? iICT_CONF_VALID : ict_valid_q[e];
      ict_level_d[e] = (iICT_VALID && (iICT_ENTRY == 6'(e))) ? iICT_CONF_LEVEL : ict_level_q[e];
    end
  end

  // Arbitration: strictly-greater compare keeps the lowest index on ties.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_level_s = 2'd0;
    for (int unsigned s = 0; s < P_SRC; s++) begin
      if (cand_s[SW'(s)] && (!win_found_s || (eff_level_s[SW'(s)] > win_level_s))) begin
        win_found_s = 1'b1;
        win_idx_s   = SW'(s);
        win_level_s = eff_level_s[SW'(s)];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Dispatch FSM next-state; once ACTIVE, lock and ICT no longer matter.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    num_d      = num_q;
    ack_fire_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s && !iEXCEPTION_LOCK) begin
          state_d = ST_ACTIVE;
          sel_d   = win_idx_s;
          num_d   = 7'(P_EXT_BASE) + 7'(win_idx_s);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (iEXCEPTION_IRQ_ACK) begin
          state_d    = ST_IDLE;
          ack_fire_s = 1'b1;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending bits: set wins over the completion clear; ack pulse blocks re-pend.
  always_comb begin
    ext_ack_d = '0;
    if (ack_fire_s) begin
      ext_ack_d[sel_q] = 1'b1;
    end else begin
      ext_ack_d = '0;
    end
    prev_d    = iEXT_IRQ;
    trig_s    = iEXT_IRQ & ~(P_EDGE_MASK & prev_q);
    pending_d = (pending_q & ~ext_ack_d) | (trig_s & enabled_s & ~ext_ack_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      num_q       <= 7'd0;
      pending_q   <= '0;
      prev_q      <= '0;
      ext_ack_q   <= '0;
      ict_mask_q  <= '{default: 1'b0};
      ict_valid_q <= '{default: 1'b0};
      ict_level_q <= '{default: 2'd0};
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      num_q       <= num_d;
      pending_q   <= pending_d;
      prev_q      <= prev_d;
      ext_ack_q   <= ext_ack_d;
      ict_mask_q  <= ict_mask_d;
      ict_valid_q <= ict_valid_d;
      ict_level_q <= ict_level_d;
    end
  end

  assign oEXT_ACK           = ext_ack_q;
  assign oPENDING           = pending_q;
  assign oEXCEPTION_ACTIVE  = (state_q == ST_ACTIVE);
  assign oEXCEPTION_IRQ_NUM = num_q;

endmodule

// File: doc/irq_priority_control.md
# irq_priority_control

Parametrised external-interrupt controller that succeeds the single-line interrupt controller. It accepts P_SRC independent request lines, each configurable as level- or edge-triggered, and latches them into per-source pending bits. It filters them through the 64-entry Interrupt Configuration Table (ICT) and a priority floor, then arbitrates by level. The selected vector is presented to the exception manager with a hold-until-ack handshake, and the source is acknowledged on completion.

## Interface
Parameters:
- P_SRC, 8: number of external request lines (1..60).
- P_EXT_BASE, 4: ICT entry / vector offset of source 0; P_EXT_BASE+P_SRC <= 64.
- P_EDGE_MASK, {P_SRC{1'b0}}: bit s=1 makes source s rising-edge triggered; 0 makes it level-triggered.

Ports:
- iCLOCK  in  1  sole clock; all state changes on its rising edge.
- iRESET_SYNC  in  1  synchronous, active-high reset.
- iICT_VALID  in  1  ICT write strobe.
- iICT_ENTRY  in  6  ICT entry index.
- iICT_CONF_MASK  in  1  entry enable (1 = interrupt allowed).
- iICT_CONF_VALID  in  1  entry configured.
- iICT_CONF_LEVEL  in  2  entry priority level (3 is the highest).
- iPRIORITY_FLOOR  in  2  minimum level eligible for dispatch.
- iEXT_IRQ  in  P_SRC  request lines.
- oEXT_ACK  out  P_SRC  one-cycle acknowledge pulse per source.
- oPENDING  out  P_SRC  pending bits (registered).
- iEXCEPTION_LOCK  in  1  exception manager busy; blocks a new dispatch.
- oEXCEPTION_ACTIVE  out  1  interrupt request to the exception manager.
- oEXCEPTION_IRQ_NUM  out  7  vector number, {1'b0, P_EXT_BASE+s}.
- iEXCEPTION_IRQ_ACK  in  1  exception manager has accepted the vector.

## Operation
- **ICT.** Each of the 64 entries holds mask, valid and level.
  - Reset clears all three fields to 0.
  - A write on iICT_VALID updates all three fields of iICT_ENTRY at the clock edge.
- **Eligibility.** Source s maps to entry e = P_EXT_BASE+s.
  - enabled(s) = !valid[e] || mask[e]. An unconfigured entry is enabled.
  - eff_level(s) = valid[e] ? level[e] : 0.
- **Trigger.**
  - Level source: trig(s) = iEXT_IRQ[s].
  - Edge source: trig(s) = iEXT_IRQ[s] && !prev[s], where prev is the registered previous value of the line. prev resets to 0.
- **Pending.**
  - pending[s] sets when trig(s) && enabled(s) && !oEXT_ACK[s].
  - pending[s] clears when source s is the one being completed (see ACTIVE).
  - If set and clear occur in the same cycle, set wins. A new edge during completion is not lost.
  - pending does not self-clear if the source is later masked; it is simply never selected while disabled.
- **Arbitration.** Candidates are pending[s] && enabled(s) && eff_level(s) >= iPRIORITY_FLOOR.
  - The winner has the highest eff_level.
  - Ties go to the lowest s.
  - Arbitration is combinational from registered state and current ICT/floor.
- **FSM**, states IDLE and ACTIVE:
  - IDLE: if a winner exists and !iEXCEPTION_LOCK, capture sel <= winner and num <= {1'b0, P_EXT_BASE+winner}, then go to ACTIVE. Otherwise stay.
  - ACTIVE: oEXCEPTION_ACTIVE=1 and oEXCEPTION_IRQ_NUM=num, held stable. Both iEXCEPTION_LOCK and ICT changes are ignored; the dispatch is committed.
  - ACTIVE with iEXCEPTION_IRQ_ACK=1: clear pending[sel], pulse oEXT_ACK[sel] next cycle, go to IDLE.
  - Unreachable encodings return to IDLE.
- **Outputs.**
  - oEXCEPTION_ACTIVE = (state==ACTIVE).
  - oEXCEPTION_IRQ_NUM = num register.
  - oEXT_ACK is a registered one-hot pulse.

## Timing
- Reset values: oEXCEPTION_ACTIVE=0, oEXCEPTION_IRQ_NUM=0, oEXT_ACK=0, oPENDING=0. State resets to IDLE, sel to 0, and every ICT field to 0.
- Reset mid-dispatch abandons the dispatch. No oEXT_ACK is issued.
- Latency, request to active:
  - iEXT_IRQ rises in cycle 0.
  - pending=1 in cycle 1.
  - oEXCEPTION_ACTIVE=1 in cycle 2, if unlocked.
- Latency, ack to source ack: iEXCEPTION_IRQ_ACK in cycle k gives oEXCEPTION_ACTIVE=0, pending cleared and oEXT_ACK[sel]=1, all in cycle k+1.
  - The earliest next dispatch is active in cycle k+2.
- Level-source re-pend: a level source still asserted in cycle k+1 is blocked by oEXT_ACK. If it is asserted in cycle k+2 it re-pends and is active in cycle k+4 at the earliest.
- Lock: a lock held in IDLE delays dispatch indefinitely. Pending bits keep accumulating meanwhile.
- ICT write and request in the same cycle: pending eligibility uses the pre-write table.

## Test plan
- **Reset.** Assert iRESET_SYNC while in ACTIVE. Required: next cycle all outputs 0, state IDLE, ICT cleared.
- **Single level source.** Source 2 is unconfigured; pulse iEXT_IRQ[2] in cycle 0. Required: oEXCEPTION_ACTIVE=1 with NUM=7'd6 in cycle 2. ACK in cycle 5 gives oEXT_ACK=8'b00000100 in cycle 6 and oPENDING=0.
- **Priority and tie.**
  - Set entry 5 (src 1) level 1 and entry 7 (src 3) level 3; raise sources 1 and 3 together. Required: NUM=7 served first, then NUM=5.
  - With equal levels on src 1 and 3, src 1 is served first.
- **Mask and floor.**
  - Entry 4 valid with mask=0: src 0 is pending only if it was latched before masking, and is never dispatched.
  - iPRIORITY_FLOOR=2 with a level-1 source: it stays pending until the floor drops to 1, then dispatches within 2 cycles.
- **Edge mode.** P_EDGE_MASK bit 0 set; hold iEXT_IRQ[0] high for 10 cycles. Required: exactly one dispatch. A new rising edge in the ACK cycle leaves pending[0]=1 and produces a second dispatch.
- **Lock.** Hold iEXCEPTION_LOCK with a source pending. Required: no ACTIVE. Release the lock: ACTIVE the following cycle. Asserting the lock during ACTIVE leaves ACTIVE and NUM unchanged until ACK.
